amber_timer: RTL and testbench

Programmable amber-phase timer for the traffic-light controller. It consumes the controller's `amber_timer_en` and produces the `timer_done` that moves the controller out of its amber states (A-amber and B-amber). A prescaler divides `clk` into ticks, and a down-counter measures the amber duration in ticks.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/amber_timer_if.sv | 26 ++
 rtl/tick_gen.sv | 29 ++
 rtl/amber_timer.sv | 86 ++++++++
 tb/tb_amber_timer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default constants for the traffic-light controller slice.
package traffic_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_DONE
  } timer_state_t;

  localparam int unsigned DEF_TICK_DIV    = 1000;
  localparam int unsigned DEF_AMBER_TICKS = 5;

endpackage

// File: rtl/amber_timer_if.sv
// Controller <-> amber timer handshake: the controller is master, the timer is slave.
interface amber_timer_if;

  logic       amber_timer_en;
  logic [7:0] cfg_ticks;
  logic       timer_done;
  logic       busy;
  logic [7:0] remaining;

  modport master (
    output amber_timer_en,
    output cfg_ticks,
    input  timer_done,
    input  busy,
    input  remaining
  );

  modport slave (
    input  amber_timer_en,
    input  cfg_ticks,
    output timer_done,
    output busy,
    output remaining
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle as a tick.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == MaxCnt) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == MaxCnt);

endmodule

// File: rtl/amber_timer.sv
// Amber-phase timer: counts the loaded duration in prescaler ticks and holds
// timer_done until the controller drops its enable.
module amber_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned AMBER_TICKS = DEF_AMBER_TICKS
) (
  input  logic          clk,
  input  logic          rstn,
  amber_timer_if.slave  tmr
);

  localparam logic [7:0] DefTicks = 8'(AMBER_TICKS);

  timer_state_t r_state, w_state_next;
  logic [7:0]   r_rem, w_rem_next;
  logic         w_tick;
  logic [7:0]   w_load;

  assign w_load = (tmr.cfg_ticks == 8'd0) ? DefTicks : tmr.cfg_ticks;

  // Holding the prescaler clear in idle makes every run start from count 0.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (r_state == T_IDLE),
    .en   (r_state == T_RUN),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= T_IDLE;
      r_rem   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    unique case (r_state)
      T_IDLE: begin
        if (tmr.amber_timer_en) begin
          w_state_next = T_RUN;
          w_rem_next   = w_load;
        end
      end
      T_RUN: begin
        // Abort beats a coincident final tick so done never glitches high.
        if (!tmr.amber_timer_en) begin
          w_state_next = T_IDLE;
          w_rem_next   = 8'd0;
        end else if (w_tick) begin
          if (r_rem <= 8'd1) begin
            w_state_next = T_DONE;
            w_rem_next   = 8'd0;
          end else begin
            w_rem_next = r_rem - 8'd1;
          end
        end
      end
      T_DONE: begin
        if (!tmr.amber_timer_en) begin
          w_state_next = T_IDLE;
        end
      end
      default: begin
        w_state_next = T_IDLE;
        w_rem_next   = 8'd0;
      end
    endcase
  end

  always_comb begin
    tmr.busy       = (r_state == T_RUN);
    tmr.timer_done = (r_state == T_DONE);
    tmr.remaining  = (r_state == T_RUN) ? r_rem : 8'd0;
  end

endmodule

// File: tb/tb_amber_timer.sv
// Self-checking bench for amber_timer: two parameterisations, a timestamp-based
// model checked every cycle, directed literals, and a small controller for the handshake.
module tb_amber_timer;

  typedef enum logic [1:0] {GA, AA, GB, BA} ctrl_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en_drv;
  logic       ctrl_mode;
  logic       traffic_b;
  logic [7:0] cfg;
  logic       en;
  ctrl_t      cs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int aa_exit = 0;
  int ba_exit = 0;

  always #5 clk = ~clk;

  amber_timer_if u_if4 ();
  amber_timer_if u_if1 ();

  assign en = ctrl_mode ? ((cs == AA) || (cs == BA)) : en_drv;
  assign u_if4.amber_timer_en = en;
  assign u_if4.cfg_ticks      = cfg;
  assign u_if1.amber_timer_en = en;
  assign u_if1.cfg_ticks      = cfg;

  amber_timer #(.TICK_DIV(4), .AMBER_TICKS(5)) u_dut4 (
    .clk  (clk),
    .rstn (rstn),
    .tmr  (u_if4)
  );

  amber_timer #(.TICK_DIV(1), .AMBER_TICKS(1)) u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .tmr  (u_if1)
  );

  logic [1:0] d_done, d_busy;
  logic [7:0] d_rem [2];
  assign d_done   = {u_if1.timer_done, u_if4.timer_done};
  assign d_busy   = {u_if1.busy, u_if4.busy};
  assign d_rem[0] = u_if4.remaining;
  assign d_rem[1] = u_if1.remaining;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is a start timestamp plus a length; done after N*D edges.
  int D [2] = '{4, 1};
  int A [2] = '{5, 1};
  int m_start [2];
  int m_n [2];
  bit m_run [2];
  bit m_done [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
      end else if (m_run[i]) begin
        if (!en) begin
          m_run[i] <= 1'b0;
        end else if (cyc - m_start[i] == m_n[i] * D[i]) begin
          m_run[i]  <= 1'b0;
          m_done[i] <= 1'b1;
        end
      end else if (m_done[i]) begin
        if (!en) m_done[i] <= 1'b0;
      end else if (en) begin
        m_run[i]   <= 1'b1;
        m_start[i] <= cyc;
        m_n[i]     <= (cfg != 8'd0) ? int'(cfg) : A[i];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        int e_rem;
        e_rem = m_run[i] ? (m_n[i] - (cyc - 1 - m_start[i]) / D[i]) : 0;
        chk((i == 0) ? "model_busy_td4" : "model_busy_td1", int'(d_busy[i]), int'(m_run[i]));
        chk((i == 0) ? "model_done_td4" : "model_done_td1", int'(d_done[i]), int'(m_done[i]));
        chk((i == 0) ? "model_rem_td4" : "model_rem_td1", int'(d_rem[i]), e_rem);
      end
    end
  end

  // Controller: leaves amber on the edge it samples done, enable follows its state.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs <= GA;
    end else begin
      case (cs)
        GA: if (traffic_b) cs <= AA;
        AA: if (u_if4.timer_done) begin
          cs      <= GB;
          aa_exit <= cyc;
        end
        GB: if (!traffic_b) cs <= BA;
        BA: if (u_if4.timer_done) begin
          cs      <= GA;
          ba_exit <= cyc;
        end
        default: cs <= GA;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en_drv = 1'b1; cfg = 8'd0; ctrl_mode = 1'b0; traffic_b = 1'b0;

    // Reset held with enable high
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", u_if4.timer_done, 0);
    chk("rst_busy", u_if4.busy, 0);
    chk("rst_rem", u_if4.remaining, 0);
    @(negedge clk) rstn = 1'b1;

    // Default duration: E0 is the next edge
    @(negedge clk); #1;
    chk("def_rem_e0", u_if4.remaining, 5);
    chk("def_busy_e0", u_if4.busy, 1);
    chk("td1_busy_e0", u_if1.busy, 1);
    @(negedge clk); #1;
    chk("td1_done_e1", u_if1.timer_done, 1);
    repeat (3) @(negedge clk); #1;
    chk("def_rem_e4", u_if4.remaining, 4);
    repeat (15) @(negedge clk); #1;
    chk("def_rem_e19", u_if4.remaining, 1);
    chk("def_done_e19", u_if4.timer_done, 0);
    @(negedge clk); #1;
    chk("def_done_e20", u_if4.timer_done, 1);
    chk("def_busy_e20", u_if4.busy, 0);
    repeat (3) @(negedge clk);
    chk("def_done_held", u_if4.timer_done, 1);
    en_drv = 1'b0;
    @(negedge clk);
    en_drv = 1'b1; cfg = 8'd2;
    #1 chk("def_done_fall", u_if4.timer_done, 0);

    // Override cfg_ticks=2; late change to 9 ignored
    @(negedge clk); #1;
    chk("ovr_rem_e0", u_if4.remaining, 2);
    repeat (3) @(negedge clk);
    cfg = 8'd9;
    repeat (4) @(negedge clk); #1;
    chk("ovr_done_e7", u_if4.timer_done, 0);
    chk("ovr_rem_e7", u_if4.remaining, 1);
    @(negedge clk);
    en_drv = 1'b0;
    #1 chk("ovr_done_e8", u_if4.timer_done, 1);
    @(negedge clk);
    en_drv = 1'b1; cfg = 8'd0;

    // Abort at E0+10, then full restart
    @(negedge clk); #1;
    chk("abt_rem_e0", u_if4.remaining, 5);
    repeat (10) @(negedge clk);
    en_drv = 1'b0;
    #1 chk("abt_rem_e10", u_if4.remaining, 3);
    @(negedge clk);
    en_drv = 1'b1;
    #1 chk("abt_busy_e11", u_if4.busy, 0);
    chk("abt_done_e11", u_if4.timer_done, 0);
    @(negedge clk); #1;
    chk("rst_rem_restart", u_if4.remaining, 5);
    repeat (19) @(negedge clk); #1;
    chk("restart_done_e19", u_if4.timer_done, 0);
    @(negedge clk); #1;
    chk("restart_done_e20", u_if4.timer_done, 1);
    en_drv = 1'b0;
    @(negedge clk);
    en_drv = 1'b1;

    // Reset mid-run at E0+7
    @(negedge clk);
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    #1 chk("mid_rst_busy", u_if4.busy, 0);
    chk("mid_rst_rem", u_if4.remaining, 0);
    chk("mid_rst_done1", u_if1.timer_done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_rem_e0", u_if4.remaining, 5);
    @(negedge clk); #1;
    chk("post_rst_td1_done", u_if1.timer_done, 1);

    // Controller integration
    en_drv = 1'b0; ctrl_mode = 1'b1;
    repeat (3) @(negedge clk);
    traffic_b = 1'b1;
    for (int k = 0; k < 60 && cs != GB; k++) @(negedge clk);
    #1 chk("a_amber_exit", int'(cs == GB), 1);
    chk("a_amber_len", aa_exit - m_start[0], 21);
    chk("done_hold_gb", u_if4.timer_done, 1);
    traffic_b = 1'b0;
    @(negedge clk); #1;
    chk("b_amber_entry", int'(cs == BA), 1);
    chk("b_amber_no_stale", u_if4.timer_done, 0);
    for (int k = 0; k < 60 && cs != GA; k++) @(negedge clk);
    #1 chk("b_amber_exit", int'(cs == GA), 1);
    chk("b_amber_len", ba_exit - m_start[0], 21);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
